// File: rtl/lpf_channel_scheduler.sv
// lpf_channel_scheduler
// One shared first-order low-pass datapath serving CHANNELS sample streams.
// Each channel keeps its own accumulator. A round-robin arbiter picks one
// requester per transaction. The filter update runs in a single CALC cycle.
// The result is offered on a valid/ready port, tagged with its channel index.
//
// Update rule per channel:
//   acc_new = acc + sext(x) - (acc >>> FILT_BITS)
//   y       = acc_new >>> FILT_BITS   (truncated to WIDTH bits)
module lpf_channel_scheduler #(
    parameter int WIDTH     = 9,
    parameter int FILT_BITS = 10,
    parameter int CHANNELS  = 4,
    parameter int CH_BITS   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          chEn,
    input  logic [CHANNELS-1:0]          clrCh,
    input  logic [CHANNELS-1:0]          inValid,
    output logic [CHANNELS-1:0]          inReady,
    input  logic [CHANNELS*WIDTH-1:0]    dataIn,
    output logic                         outValid,
    input  logic                         outReady,
    output logic [CH_BITS-1:0]           outChannel,
    output logic [WIDTH-1:0]             dataOut
);

    localparam int ACC_W = WIDTH + FILT_BITS;
    // One extra bit so rr_ptr + offset can be compared against CHANNELS
    // before it wraps.
    localparam int CW    = CH_BITS + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q [CHANNELS];
    logic signed [ACC_W-1:0]   acc_d [CHANNELS];
    logic [CH_BITS-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CH_BITS-1:0]        ch_q, ch_d;
    logic signed [WIDTH-1:0]   sample_q, sample_d;
    logic [CH_BITS-1:0]        out_channel_q, out_channel_d;
    logic signed [WIDTH-1:0]   data_out_q, data_out_d;
    logic                      out_valid_q, out_valid_d;

    // Arbitration signals.
    logic [CHANNELS-1:0]       req;
    logic [2*CHANNELS-1:0]     req2;
    logic [CHANNELS-1:0]       rot_req;
    logic [CW-1:0]             cand;
    logic                      grant_found;
    logic [CH_BITS-1:0]        grant_ch;
    logic signed [WIDTH-1:0]   grant_sample;

    // Datapath signals.
    logic signed [ACC_W-1:0]   acc_cur;
    logic signed [ACC_W-1:0]   acc_new;

    // Round-robin search: rotate the request vector so that rr_ptr sits at
    // bit 0, then take the first set bit and map it back to a channel index.
    always_comb begin
        req         = inValid & chEn;
        req2        = {req, req};
        rot_req     = CHANNELS'(req2 >> rr_ptr_q);
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = CW'(rr_ptr_q) + CW'(i);
            if (cand >= CW'(CHANNELS)) begin
                cand = cand - CW'(CHANNELS);
            end
            if (!grant_found && rot_req[i]) begin
                grant_found = 1'b1;
                grant_ch    = cand[CH_BITS-1:0];
            end
        end
    end

    // Select the granted channel's sample from the packed input bus.
    always_comb begin
        grant_sample = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_ch == CH_BITS'(k)) begin
                grant_sample = dataIn[k*WIDTH +: WIDTH];
            end
        end
    end

    // Accept is combinational and one-hot at the grant, only in IDLE and
    // never during reset.
    always_comb begin
        inReady = '0;
        if (!rst && state_q == IDLE && grant_found) begin
            inReady[grant_ch] = 1'b1;
        end
    end

    // Shared filter arithmetic for the latched channel.
    always_comb begin
        acc_cur = acc_q[ch_q];
        acc_new = acc_cur + ACC_W'(sample_q) - (acc_cur >>> FILT_BITS);
    end

    // Next-state logic for the FSM, the accumulator bank and the output register.
    always_comb begin
        // NOTE: every variable gets its hold value first. Any path that skips
        // an assignment then keeps state instead of inferring a latch.
        state_d       = state_q;
        acc_d         = acc_q;
        rr_ptr_d      = rr_ptr_q;
        ch_d          = ch_q;
        sample_d      = sample_q;
        out_channel_d = out_channel_q;
        data_out_d    = data_out_q;
        out_valid_d   = out_valid_q;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    ch_d     = grant_ch;
                    sample_d = grant_sample;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d[ch_q]   = acc_new;
                data_out_d    = WIDTH'(acc_new >>> FILT_BITS);
                out_channel_d = ch_q;
                out_valid_d   = 1'b1;
                state_d       = OUT;
            end
            OUT: begin
                if (outReady) begin
                    out_valid_d = 1'b0;
                    rr_ptr_d    = (ch_q == CH_BITS'(CHANNELS - 1)) ? '0
                                                                   : ch_q + CH_BITS'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear overrides a CALC write to the same channel. The result
        // already computed in that CALC is still emitted.
        for (int k = 0; k < CHANNELS; k++) begin
            if (clrCh[k]) begin
                acc_d[k] = '0;
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. All flops
        // then sample their _d values from the same pre-edge snapshot.
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            ch_q          <= '0;
            sample_q      <= '0;
            out_channel_q <= '0;
            data_out_q    <= '0;
            out_valid_q   <= 1'b0;
            // NOTE: the accumulator bank is reset explicitly. A filter must
            // start from zero, so this array cannot be left uninitialised
            // like a plain data RAM.
            for (int k = 0; k < CHANNELS; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            ch_q          <= ch_d;
            sample_q      <= sample_d;
            out_channel_q <= out_channel_d;
            data_out_q    <= data_out_d;
            out_valid_q   <= out_valid_d;
            for (int k = 0; k < CHANNELS; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign outValid   = out_valid_q;
    assign outChannel = out_channel_q;
    assign dataOut    = data_out_q;

endmodule

// File: tb/tb_lpf_channel_scheduler.sv
// Testbench for lpf_channel_scheduler with FILT_BITS=2.
// Directed stimulus pushes hand-computed {channel, value} pairs into a queue.
// A negedge monitor pops and compares them on every output handshake.
module tb_lpf_channel_scheduler;

    localparam int WIDTH     = 9;
    localparam int FILT_BITS = 2;
    localparam int CHANNELS  = 4;
    localparam int CH_BITS   = 2;

    logic                      clk;
    logic                      rst;
    logic [CHANNELS-1:0]       ch_en;
    logic [CHANNELS-1:0]       clr_ch;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [CH_BITS-1:0]        out_channel;
    logic [WIDTH-1:0]          data_out;

    typedef struct {
        int ch;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   accept_cyc = 0;
    logic prev_ov = 1'b0;

    lpf_channel_scheduler #(
        .WIDTH(WIDTH), .FILT_BITS(FILT_BITS), .CHANNELS(CHANNELS), .CH_BITS(CH_BITS)
    ) dut (
        .clk(clk), .rst(rst), .chEn(ch_en), .clrCh(clr_ch), .inValid(in_valid),
        .inReady(in_ready), .dataIn(data_in), .outValid(out_valid), .outReady(out_ready),
        .outChannel(out_channel), .dataOut(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int ch, input int val);
        exp_t e;
        e.ch  = ch;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Monitor: accept-to-valid latency, one-hot accept, scoreboard pops.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("in_ready_onehot0", int'($onehot0(in_ready)), 1);
            if (|(in_ready & in_valid)) accept_cyc = cyc;
            if (out_valid && !prev_ov) check("latency", cyc - accept_cyc, 2);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: ch=%0d data=%0d, none expected",
                             out_channel, $signed(data_out));
                end else begin
                    e = exp_q.pop_front();
                    check("out_channel", int'(out_channel), e.ch);
                    check("data_out", int'($signed(data_out)), e.val);
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic set_sample(input int ch, input int x);
        logic [WIDTH-1:0] xv;
        xv = x[WIDTH-1:0];
        data_in[ch*WIDTH +: WIDTH] = xv;
    endtask

    task automatic set_all(input int x);
        for (int k = 0; k < CHANNELS; k++) set_sample(k, x);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = '0;
        clr_ch   = '0;
        ch_en    = '1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Offer one sample on one channel and wait for its accept. The clear
    // can optionally be pulsed on the CALC edge.
    task automatic send(input int ch, input int x, input bit clr_in_calc);
        int guard = 0;
        set_sample(ch, x);
        in_valid[ch] = 1'b1;
        while (guard < 100) begin
            @(negedge clk);
            if (in_ready[ch]) break;
            guard++;
        end
        check("send_accepted", int'(guard < 100), 1);
        @(posedge clk);
        #1;
        in_valid[ch] = 1'b0;
        if (clr_in_calc) begin
            clr_ch[ch] = 1'b1;
            @(posedge clk);
            #1;
            clr_ch[ch] = 1'b0;
        end
    endtask

    // Hold all channels valid until n grants occur. Check grant spacing
    // and that no disabled channel is granted.
    task automatic run_all(input int n);
        int k = 0;
        int last = 0;
        int guard = 0;
        in_valid = '1;
        while (k < n && guard < 200) begin
            @(negedge clk);
            guard++;
            if (|(in_ready & in_valid)) begin
                check("grant_enabled", int'(|(in_ready & ~ch_en)), 0);
                if (k > 0) check("grant_spacing", cyc - last, 3);
                last = cyc;
                k++;
            end
        end
        check("run_all_grants", k, n);
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        ch_en     = '1;
        clr_ch    = '0;
        in_valid  = '1;
        out_ready = 1'b1;
        data_in   = '0;
        set_all(100);

        // Reset: inReady is held low even with every channel requesting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_data_out", int'(data_out), 0);
        #1;
        in_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle for 20 cycles with no requests.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_in_ready", int'(in_ready), 0);
            check("idle_out_valid", int'(out_valid), 0);
            check("idle_data_out", int'(data_out), 0);
        end

        // Step of 100 on channel 1: 25,43,58,68,76,82.
        do_reset();
        push_exp(1, 25); push_exp(1, 43); push_exp(1, 58);
        push_exp(1, 68); push_exp(1, 76); push_exp(1, 82);
        for (int i = 0; i < 6; i++) send(1, 100, 1'b0);
        drain();

        // Negative step on channel 0: -64, -112.
        do_reset();
        push_exp(0, -64); push_exp(0, -112);
        send(0, -256, 1'b0);
        send(0, -256, 1'b0);
        drain();

        // Round-robin with all channels valid.
        do_reset();
        set_all(100);
        push_exp(0, 25); push_exp(1, 25); push_exp(2, 25); push_exp(3, 25);
        push_exp(0, 43); push_exp(1, 43);
        run_all(6);
        drain();

        // Backpressure: the result holds while outReady is low.
        do_reset();
        set_all(100);
        out_ready = 1'b0;
        push_exp(0, 25);
        send(0, 100, 1'b0);
        in_valid = '1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_data_out", int'($signed(data_out)), 25);
            check("bp_out_channel", int'(out_channel), 0);
            check("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid  = '0;
        out_ready = 1'b1;
        drain();

        // Masking: channel 2 disabled keeps its accumulator (100).
        do_reset();
        set_all(100);
        push_exp(2, 25);
        send(2, 100, 1'b0);
        drain();
        ch_en = 4'b1011;
        push_exp(3, 25); push_exp(0, 25); push_exp(1, 25);
        push_exp(3, 43); push_exp(0, 43); push_exp(1, 43);
        run_all(6);
        drain();
        ch_en = '1;
        push_exp(2, 43);
        send(2, 100, 1'b0);
        drain();

        // Clear while idle, then clear coincident with CALC.
        do_reset();
        push_exp(3, 25); push_exp(3, 43); push_exp(3, 58);
        for (int i = 0; i < 3; i++) send(3, 100, 1'b0);
        drain();
        clr_ch[3] = 1'b1;
        @(posedge clk);
        #1;
        clr_ch[3] = 1'b0;
        push_exp(3, 25);
        send(3, 100, 1'b0);
        drain();
        push_exp(3, 43);
        send(3, 100, 1'b1);
        drain();
        push_exp(3, 25);
        send(3, 100, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
